// File: rtl/fifo_param.sv
// First-word-fall-through FIFO for any depth >= 2, with occupancy, almost-full/empty flags and flush; write to data_o takes 1 cycle.
// Backpressure: data_i_ready drops only when full (even if a read happens that cycle); all outputs come from registers.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 6,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int IDX_WIDTH = ($clog2(FIFO_DEPTH) > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_i_valid,
    output logic                  data_i_ready,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_o_valid,
    input  logic                  data_o_ready,
    output logic [CNT_WIDTH-1:0]  occupancy_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C     = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_C     = CNT_WIDTH'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [IDX_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 wr_en;
    logic                 rd_en;

    // Explicit wrap compare so non-power-of-two depths work.
    function automatic logic [IDX_WIDTH-1:0] ptr_inc(input logic [IDX_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IDX_WIDTH'(1);
    endfunction

    assign data_i_ready   = (count_q != DEPTH_C);
    assign data_o_valid   = (count_q != '0);
    assign data_o         = mem_q[rd_ptr_q];
    assign occupancy_o    = count_q;
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);

    assign wr_en = data_i_valid && data_i_ready;
    assign rd_en = data_o_valid && data_o_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_en && !rd_en)      count_d = count_q + CNT_WIDTH'(1);
            else if (rd_en && !wr_en) count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a write is dropped when reset or flush wins the cycle.
    always_ff @(posedge clk) begin
        if (!reset_i && !flush_i && wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: queue-based reference model checked every cycle, plus hand-computed literals.
module tb_fifo_param;
    localparam int D  = 6;
    localparam int AF = D - 1;
    localparam int AE = 1;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic [31:0] data_i;
    logic        data_i_valid;
    logic        data_i_ready;
    logic [31:0] data_o;
    logic        data_o_valid;
    logic        data_o_ready;
    logic [2:0]  occupancy_o;
    logic        almost_full_o;
    logic        almost_empty_o;

    always #5 clk = ~clk;

    fifo_param dut (
        .clk(clk), .reset_i(reset_i), .flush_i(flush_i),
        .data_i(data_i), .data_i_valid(data_i_valid), .data_i_ready(data_i_ready),
        .data_o(data_o), .data_o_valid(data_o_valid), .data_o_ready(data_o_ready),
        .occupancy_o(occupancy_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq[$];
    bit          chk_en = 0;
    bit          ff_seen = 0;
    bit          acc;
    int          obs_reads = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue bounded at D entries.
    always @(posedge clk) begin : model
        bit w, r;
        if (reset_i) begin
            mq.delete();
            chk_en = 1;
        end else if (flush_i) begin
            mq.delete();
        end else begin
            if (data_o_valid === 1'b1 && data_o_ready) obs_reads++;
            w = data_i_valid && (mq.size() < D);
            r = data_o_ready && (mq.size() > 0);
            if (r) void'(mq.pop_front());
            if (w) mq.push_back(data_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", data_i_ready, mq.size() < D);
            chk("valid", data_o_valid, mq.size() > 0);
            chk("occ", occupancy_o, mq.size());
            chk("af", almost_full_o, mq.size() >= AF);
            chk("ae", almost_empty_o, mq.size() <= AE);
            if (mq.size() > 0) chk("data", data_o, mq[0]);
            if (data_o_valid && data_o == 32'hFF) ff_seen = 1;
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f, input logic rs);
        @(negedge clk);
        acc          = v && data_i_ready && !f && !rs;
        data_i_valid = v;
        data_i       = d;
        data_o_ready = r;
        flush_i      = f;
        reset_i      = rs;
    endtask

    task automatic drain_all(output int n);
        n = 0;
        for (int g = 0; g < 50; g++) begin
            cyc(0, 0, 1, 0, 0);
            if (!data_o_valid) break;
            n++;
        end
        chk("drain_empty", data_o_valid, 0);
    endtask

    task automatic idle_state(input string tag);
        chk({tag, "_ready"}, data_i_ready, 1);
        chk({tag, "_valid"}, data_o_valid, 0);
        chk({tag, "_occ"}, occupancy_o, 0);
        chk({tag, "_ae"}, almost_empty_o, 1);
        chk({tag, "_af"}, almost_full_o, 0);
    endtask

    initial begin
        int n;
        int base;
        int idx;
        reset_i = 1; flush_i = 0; data_i_valid = 0; data_o_ready = 0; data_i = 0;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        idle_state("rst");

        for (int i = 0; i < 6; i++) begin
            cyc(1, 32'hA0 + i, 0, 0, 0);
            if (i > 0) begin
                chk("fill_occ", occupancy_o, i);
                chk("fill_af", almost_full_o, i >= 5);
            end
        end
        cyc(1, 32'hA6, 0, 0, 0);
        chk("full_occ", occupancy_o, 6);
        chk("full_ready", data_i_ready, 0);
        chk("a6_held", acc, 0);
        cyc(1, 32'hA6, 0, 0, 0);
        chk("full_occ2", occupancy_o, 6);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk("drain_seq", data_o, 32'hA0 + i);
        end
        cyc(0, 0, 0, 0, 0);
        chk("drained_valid", data_o_valid, 0);
        chk("drained_occ", occupancy_o, 0);

        base = obs_reads;
        idx  = 0;
        for (int g = 0; g < 200 && idx < 20; g++) begin
            cyc(1, 32'hB0 + idx, (g % 2) == 0, 0, 0);
            if (acc) idx++;
        end
        drain_all(n);
        chk("stream_words", idx, 20);
        chk("stream_reads", (obs_reads - base) >= 20, 1);

        for (int i = 0; i < 3; i++) cyc(1, 32'hC0 + i, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 32'hD0 + k, 1, 0, 0);
            chk("sim_occ", occupancy_o, 3);
            chk("sim_data", data_o, (k < 3) ? 32'hC0 + k : 32'hD0 + k - 3);
        end
        drain_all(n);
        chk("sim_drain_n", n, 3);

        for (int i = 0; i < 6; i++) cyc(1, 32'hE0 + i, 0, 0, 0);
        cyc(1, 32'hEE, 1, 0, 0);
        chk("fullrw_ready", data_i_ready, 0);
        chk("fullrw_acc", acc, 0);
        cyc(0, 0, 0, 0, 0);
        chk("fullrw_occ", occupancy_o, 5);
        chk("fullrw_head", data_o, 32'hE1);
        drain_all(n);
        chk("fullrw_n", n, 5);

        for (int i = 0; i < 4; i++) cyc(1, 32'hF0 + i, 0, 0, 0);
        cyc(1, 32'hFF, 0, 1, 0);
        chk("pre_flush_occ", occupancy_o, 4);
        cyc(0, 0, 0, 0, 0);
        idle_state("flush");
        cyc(1, 32'h11, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("post_flush_valid", data_o_valid, 1);
        chk("post_flush_data", data_o, 32'h11);
        chk("post_flush_occ", occupancy_o, 1);
        drain_all(n);
        chk("post_flush_n", n, 1);
        chk("ff_never_out", ff_seen, 0);

        for (int i = 0; i < 5; i++) cyc(1, 32'h30 + i, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(1, 32'h40 + k, 1, 0, 0);
        chk("pre_rst_occ", occupancy_o, 5);
        cyc(1, 32'h77, 1, 0, 1);
        cyc(0, 0, 0, 0, 0);
        idle_state("midrst");
        cyc(1, 32'h55, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("resume_data", data_o, 32'h55);
        chk("resume_occ", occupancy_o, 1);
        drain_all(n);
        chk("resume_n", n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Next-generation parametrised synchronous FIFO for buffet/fill-drain datapaths.
- Ready/valid on both sides with first-word-fall-through output.
- Any depth ≥ 2, not only powers of two. Occupancy is held in an explicit count register.
- Adds programmable almost-full/almost-empty flags, an occupancy output, and a synchronous flush so upstream controllers can throttle and drain without probing pointers.

Parameters:
DATA_WIDTH, 32, width of each entry
FIFO_DEPTH, 6, number of entries; any integer ≥ 2
AF_THRESH, FIFO_DEPTH-1, almost_full_o asserted when occupancy ≥ AF_THRESH; legal range 1..FIFO_DEPTH
AE_THRESH, 1, almost_empty_o asserted when occupancy ≤ AE_THRESH; legal range 0..FIFO_DEPTH-1
(derived) IDX_WIDTH = max(1,$clog2(FIFO_DEPTH)); CNT_WIDTH = $clog2(FIFO_DEPTH+1)

Ports:
clk  input  1  clock, all state on rising edge
reset_i  input  1  synchronous active-high reset
flush_i  input  1  synchronous discard of all contents
data_i  input  DATA_WIDTH  write data
data_i_valid  input  1  write request
data_i_ready  output  1  FIFO can accept a word this cycle
data_o  output  DATA_WIDTH  head-of-queue data (FWFT)
data_o_valid  output  1  data_o holds a valid entry
data_o_ready  input  1  consumer takes data_o this cycle
occupancy_o  output  CNT_WIDTH  current entry count, 0..FIFO_DEPTH
almost_full_o  output  1  occupancy_o ≥ AF_THRESH
almost_empty_o  output  1  occupancy_o ≤ AE_THRESH

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset_i. No asynchronous reset anywhere.
- Reset values: wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: data_i_ready=1, data_o_valid=0, occupancy_o=0, almost_full_o=0, almost_empty_o=1.
  - Storage array is not reset. data_o is don't-care while data_o_valid=0.
- reset_i asserted mid-operation: state takes reset values on that edge. Contents are lost. Any handshake in that cycle is ignored.
- All outputs derive from registers only; there is no combinational path from inputs to outputs.
  - data_i_ready = (count != FIFO_DEPTH); data_o_valid = (count != 0); data_o = mem[rd_ptr].
  - Flags compare count against thresholds.
- Events:
  - wr = data_i_valid & data_i_ready.
  - rd = data_o_valid & data_o_ready.
  - data_i_valid while not ready is a stall, not an error. Nothing is written.
- Write: on wr, mem[wr_ptr] ← data_i and wr_ptr advances.
- Read: on rd, rd_ptr advances.
- Pointer wrap: a pointer at FIFO_DEPTH-1 returns to 0. Explicit compare is required; binary overflow is not used, so non-power-of-2 depths work.
- Count update: +1 on wr only, −1 on rd only, unchanged on both or neither. Count never leaves 0..FIFO_DEPTH.
- Latency: a word written at edge N is visible on data_o with data_o_valid=1 after edge N (one cycle, empty → valid).
- Full boundary: with count=FIFO_DEPTH, data_i_ready=0 even if data_o_ready=1 in the same cycle.
  - The read completes; ready rises the next cycle.
  - Simultaneous read and write at full is not possible by construction.
- Empty boundary: with count=0, data_o_valid=0, so data_o_ready is ignored. A write in that cycle is accepted and count becomes 1.
- Simultaneous wr and rd at 0<count<FIFO_DEPTH: both pointers advance and count is unchanged.
  - If wr_ptr==rd_ptr cannot occur here, ordering is irrelevant.
  - Read data is the old head.
- Flush: flush_i=1 sets wr_ptr=rd_ptr=count=0 on that edge, so outputs match reset next cycle.
  - Flush has priority over any wr/rd in the same cycle; the incoming word is dropped and the read is still counted by the consumer as taken.
  - The consumer must not assert data_o_ready with flush_i; the bench treats it as don't-care.
- Priority: reset_i > flush_i > normal operation.
- Flags update the cycle after count changes, because they are pure functions of the count register.

Test Plan:
- Reset then idle: after reset_i high for 2 cycles → data_i_ready=1, data_o_valid=0, occupancy_o=0, almost_empty_o=1, almost_full_o=0.
- Fill depth 6 with 0xA0..0xA5, no reads:
  - Occupancy steps 1..6.
  - almost_full_o rises when occupancy_o=5.
  - data_i_ready=0 at 6; a seventh valid word 0xA6 is held and not written.
  - Then drain → data_o sequence 0xA0..0xA5, data_o_valid=0 after the last.
- Wrap-around at depth 6:
  - Continuous streaming of 20 words with data_o_ready toggling 1,0,1,…
  - Output order equals input order, occupancy_o stays ≤ 6, and pointers pass 5→0 at least three times.
- Simultaneous read/write:
  - With occupancy 3, hold data_i_valid=data_o_ready=1 for 10 cycles → occupancy_o stays 3 and outputs are in order.
  - At occupancy 6 with data_o_ready=1 and data_i_valid=1 → occupancy 5 next cycle and no word is written that cycle.
- Flush:
  - With occupancy 4, assert flush_i with data_i_valid=1 (0xFF) → next cycle occupancy_o=0, data_o_valid=0.
  - 0xFF never appears on data_o.
  - A subsequent write 0x11 appears on data_o one cycle later.
- Mid-operation reset: at occupancy 5 with streaming active, pulse reset_i for one cycle → all outputs equal reset values next cycle, and traffic resumes correctly.
